// File: rtl/branch_hazard_unit.sv
// ID-stage forwarding select, branch/load-use stall sequencing, taken-branch flush
// and a saturating stall-cycle statistic for the 5-stage MIPS pipeline.
module branch_hazard_unit #(
   parameter int unsigned AW   = 5,
   parameter int unsigned NSRC = 2,
   parameter int unsigned CW   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_branch,
   input  logic [NSRC*AW-1:0] id_src,
   input  logic [NSRC-1:0]   id_src_used,
   input  logic              branch_taken,
   input  logic              idex_regwrite,
   input  logic              idex_memread,
   input  logic [AW-1:0]     idex_dst,
   input  logic              exmem_regwrite,
   input  logic              exmem_memread,
   input  logic [AW-1:0]     exmem_dst,
   input  logic              memwb_regwrite,
   input  logic [AW-1:0]     memwb_dst,
   input  logic              stat_clear,
   output logic [2*NSRC-1:0] fwd_sel,
   output logic              stall,
   output logic              bubble_idex,
   output logic              flush_ifid,
   output logic [CW-1:0]     stall_cycles
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t        state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [1:0]    need;
   logic [CW-1:0] stall_cycles_q, stall_cycles_d;

   always_comb begin : hazard_detect
      logic [AW-1:0] src;
      logic [1:0]    pn;
      src     = '0;
      pn      = '0;
      need    = '0;
      fwd_sel = '0;
      for (int unsigned p = 0; p < NSRC; p++) begin
         src = id_src[p*AW +: AW];
         pn  = '0;
         if (id_src_used[p] && (src != '0)) begin
            if (exmem_regwrite && !exmem_memread && (exmem_dst == src))
               fwd_sel[2*p +: 2] = 2'b01;
            else if (memwb_regwrite && (memwb_dst == src))
               fwd_sel[2*p +: 2] = 2'b11;

            if (id_branch && idex_regwrite && (idex_dst == src))
               pn = idex_memread ? 2'd2 : 2'd1;
            else if (id_branch && exmem_regwrite && exmem_memread && (exmem_dst == src))
               pn = 2'd1;
            else if (!id_branch && idex_memread && (idex_dst == src))
               pn = 2'd1;
         end
         if (pn > need)
            need = pn;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The IDLE cycle that detects the hazard is the first stall cycle, so HOLD
   // only covers the remaining need-1 cycles.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (need != 2'd0) begin
               cnt_d = need - 2'd1;
               if (need == 2'd2)
                  state_d = HOLD;
            end
         end
         HOLD: begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q <= 2'd1) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      stall       = (state_q == HOLD) || (need != 2'd0);
      bubble_idex = stall;
      flush_ifid  = id_branch & branch_taken & ~stall;
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stat_clear)
         stall_cycles_d = '0;
      else if (stall && (stall_cycles_q != '1))
         stall_cycles_d = stall_cycles_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cycles_q <= '0;
      else
         stall_cycles_q <= stall_cycles_d;
   end

   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Self-checking bench for branch_hazard_unit: vector table, directed multi-cycle
// sequences, and randomized traffic against a cycle-level reference model.
module tb_branch_hazard_unit;

   localparam int unsigned AW = 5;
   localparam int unsigned NSRC = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          id_branch, branch_taken;
   logic [AW-1:0] src0, src1;
   logic [1:0]    id_src_used;
   logic          idex_regwrite, idex_memread;
   logic [AW-1:0] idex_dst;
   logic          exmem_regwrite, exmem_memread;
   logic [AW-1:0] exmem_dst;
   logic          memwb_regwrite;
   logic [AW-1:0] memwb_dst;
   logic          stat_clear;

   logic [3:0]  fwd_sel, fwd_sel2;
   logic        stall, bubble_idex, flush_ifid;
   logic        stall2, bubble2, flush2;
   logic [15:0] stall_cycles;
   logic [1:0]  stall_cycles2;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   branch_hazard_unit #(.AW(AW), .NSRC(NSRC), .CW(16)) dut (
      .clk(clk), .reset(reset), .id_branch(id_branch), .id_src({src1, src0}),
      .id_src_used(id_src_used), .branch_taken(branch_taken),
      .idex_regwrite(idex_regwrite), .idex_memread(idex_memread), .idex_dst(idex_dst),
      .exmem_regwrite(exmem_regwrite), .exmem_memread(exmem_memread), .exmem_dst(exmem_dst),
      .memwb_regwrite(memwb_regwrite), .memwb_dst(memwb_dst), .stat_clear(stat_clear),
      .fwd_sel(fwd_sel), .stall(stall), .bubble_idex(bubble_idex),
      .flush_ifid(flush_ifid), .stall_cycles(stall_cycles)
   );

   branch_hazard_unit #(.AW(AW), .NSRC(NSRC), .CW(2)) dut2 (
      .clk(clk), .reset(reset), .id_branch(id_branch), .id_src({src1, src0}),
      .id_src_used(id_src_used), .branch_taken(branch_taken),
      .idex_regwrite(idex_regwrite), .idex_memread(idex_memread), .idex_dst(idex_dst),
      .exmem_regwrite(exmem_regwrite), .exmem_memread(exmem_memread), .exmem_dst(exmem_dst),
      .memwb_regwrite(memwb_regwrite), .memwb_dst(memwb_dst), .stat_clear(stat_clear),
      .fwd_sel(fwd_sel2), .stall(stall2), .bubble_idex(bubble2),
      .flush_ifid(flush2), .stall_cycles(stall_cycles2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      id_branch = 0; branch_taken = 0; src0 = 0; src1 = 0; id_src_used = 0;
      idex_regwrite = 0; idex_memread = 0; idex_dst = 0;
      exmem_regwrite = 0; exmem_memread = 0; exmem_dst = 0;
      memwb_regwrite = 0; memwb_dst = 0; stat_clear = 0;
   endtask

   typedef struct {
      logic br, tk;
      logic [AW-1:0] s0, s1;
      logic [1:0] used;
      logic ir, im; logic [AW-1:0] id;
      logic er, em; logic [AW-1:0] ed;
      logic wr;     logic [AW-1:0] wd;
      logic [3:0] e_fwd; logic e_stall, e_flush;
   } vec_t;

   vec_t vt [10];

   // Reference: spec rules stated per source register, need = worst over used ports.
   function automatic logic [1:0] ref_fwd1(input logic [AW-1:0] s, input logic u);
      if (!u || s == 0) return 2'b00;
      if (exmem_regwrite && !exmem_memread && exmem_dst == s) return 2'b01;
      if (memwb_regwrite && memwb_dst == s) return 2'b11;
      return 2'b00;
   endfunction

   function automatic int ref_need1(input logic [AW-1:0] s, input logic u);
      if (!u || s == 0) return 0;
      if (id_branch && idex_regwrite && idex_dst == s) return idex_memread ? 2 : 1;
      if (id_branch && exmem_regwrite && exmem_memread && exmem_dst == s) return 1;
      if (!id_branch && idex_memread && idex_dst == s) return 1;
      return 0;
   endfunction

   int hold_left, cnt16, cnt2, need_m, n0, n1;
   logic exp_stall;

   initial begin
      clr_in();
      reset = 1;
      #12;
      chk("reset_fwd", {28'd0, fwd_sel}, 0);
      chk("reset_stall", {31'd0, stall}, 0);
      chk("reset_bubble", {31'd0, bubble_idex}, 0);
      chk("reset_flush", {31'd0, flush_ifid}, 0);
      chk("reset_stall_cycles", {16'd0, stall_cycles}, 0);
      reset = 0;
      tick();

      //        br tk s0 s1 used ir im id er em ed wr wd  fwd    st fl
      vt[0] = '{0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0};
      vt[1] = '{0, 0, 5, 0, 2'b11, 0, 0, 0, 1, 0, 5, 1, 5, 4'b0001, 0, 0};
      vt[2] = '{0, 0, 0, 7, 2'b10, 0, 0, 0, 0, 0, 0, 1, 7, 4'b1100, 0, 0};
      vt[3] = '{0, 0, 6, 0, 2'b01, 0, 0, 0, 1, 1, 6, 1, 6, 4'b0011, 0, 0};
      vt[4] = '{1, 1, 6, 0, 2'b01, 0, 0, 0, 1, 1, 6, 1, 6, 4'b0011, 1, 0};
      vt[5] = '{1, 1, 1, 2, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 1};
      vt[6] = '{1, 0, 8, 0, 2'b00, 1, 0, 8, 1, 0, 8, 0, 0, 4'b0000, 0, 0};
      vt[7] = '{0, 0, 0, 3, 2'b10, 1, 1, 3, 0, 0, 0, 0, 0, 4'b0000, 1, 0};
      vt[8] = '{1, 0, 0, 0, 2'b11, 1, 0, 0, 1, 0, 0, 1, 0, 4'b0000, 0, 0};
      vt[9] = '{1, 1, 8, 4, 2'b11, 1, 0, 8, 0, 0, 0, 1, 4, 4'b1100, 1, 0};

      for (int i = 0; i < 10; i++) begin
         id_branch = vt[i].br; branch_taken = vt[i].tk;
         src0 = vt[i].s0; src1 = vt[i].s1; id_src_used = vt[i].used;
         idex_regwrite = vt[i].ir; idex_memread = vt[i].im; idex_dst = vt[i].id;
         exmem_regwrite = vt[i].er; exmem_memread = vt[i].em; exmem_dst = vt[i].ed;
         memwb_regwrite = vt[i].wr; memwb_dst = vt[i].wd;
         #2;
         chk($sformatf("vec%0d_fwd", i), {28'd0, fwd_sel}, {28'd0, vt[i].e_fwd});
         chk($sformatf("vec%0d_stall", i), {31'd0, stall}, {31'd0, vt[i].e_stall});
         chk($sformatf("vec%0d_bubble", i), {31'd0, bubble_idex}, {31'd0, vt[i].e_stall});
         chk($sformatf("vec%0d_flush", i), {31'd0, flush_ifid}, {31'd0, vt[i].e_flush});
         clr_in();
         tick();
      end

      // ALU op in ID/EX feeding a branch: one stall cycle, then EX/MEM forward.
      stat_clear = 1; tick(); stat_clear = 0;
      id_branch = 1; src0 = 8; id_src_used = 2'b01; idex_regwrite = 1; idex_dst = 8;
      #2 chk("alu_br_stall", {31'd0, stall}, 1);
      tick();
      idex_regwrite = 0; idex_dst = 0; exmem_regwrite = 1; exmem_dst = 8;
      #2 chk("alu_br_fwd", {30'd0, fwd_sel[1:0]}, 2'b01);
      chk("alu_br_nostall", {31'd0, stall}, 0);
      chk("alu_br_cycles", {16'd0, stall_cycles}, 1);
      clr_in(); tick();

      // Load in ID/EX feeding a taken branch: exactly two stall cycles, no flush meanwhile.
      stat_clear = 1; tick(); stat_clear = 0;
      id_branch = 1; branch_taken = 1; src1 = 9; id_src_used = 2'b10;
      idex_regwrite = 1; idex_memread = 1; idex_dst = 9;
      #2 chk("ld_br_stall1", {31'd0, stall}, 1);
      chk("ld_br_noflush1", {31'd0, flush_ifid}, 0);
      tick();
      idex_regwrite = 0; idex_memread = 0; idex_dst = 0;
      exmem_regwrite = 1; exmem_memread = 1; exmem_dst = 9;
      #2 chk("ld_br_stall2", {31'd0, stall}, 1);
      chk("ld_br_noflush2", {31'd0, flush_ifid}, 0);
      tick();
      exmem_regwrite = 0; exmem_memread = 0; exmem_dst = 0; memwb_regwrite = 1; memwb_dst = 9;
      #2 chk("ld_br_stall3", {31'd0, stall}, 0);
      chk("ld_br_fwd", {30'd0, fwd_sel[3:2]}, 2'b11);
      chk("ld_br_flush", {31'd0, flush_ifid}, 1);
      chk("ld_br_cycles", {16'd0, stall_cycles}, 2);
      clr_in(); tick();

      // Reset asserted while in HOLD drops stall without a clock edge.
      id_branch = 1; src0 = 9; id_src_used = 2'b01;
      idex_regwrite = 1; idex_memread = 1; idex_dst = 9;
      tick();
      clr_in();
      #1 chk("hold_stall", {31'd0, stall}, 1);
      reset = 1;
      #1 chk("rst_hold_stall", {31'd0, stall}, 0);
      chk("rst_hold_cycles", {16'd0, stall_cycles}, 0);
      reset = 0;
      tick();

      // Five consecutive stalled cycles: CW=2 counter saturates at 3; clear wins over increment.
      src1 = 3; id_src_used = 2'b10; idex_regwrite = 1; idex_memread = 1; idex_dst = 3;
      for (int i = 0; i < 5; i++) tick();
      #1 chk("sat_cw2", {30'd0, stall_cycles2}, 3);
      chk("sat_cw16", {16'd0, stall_cycles}, 5);
      stat_clear = 1; tick(); stat_clear = 0;
      chk("clear_cw2", {30'd0, stall_cycles2}, 0);
      chk("clear_cw16", {16'd0, stall_cycles}, 0);
      clr_in();

      // Randomized traffic against the reference model.
      reset = 1; #2 reset = 0;
      tick();
      hold_left = 0; cnt16 = 0; cnt2 = 0;
      for (int i = 0; i < 600; i++) begin
         id_branch = 1'($urandom_range(0, 1)); branch_taken = 1'($urandom_range(0, 1));
         src0 = AW'($urandom_range(0, 3)); src1 = AW'($urandom_range(0, 3));
         id_src_used = 2'($urandom_range(0, 3));
         idex_regwrite = 1'($urandom_range(0, 1)); idex_memread = 1'($urandom_range(0, 1));
         idex_dst = AW'($urandom_range(0, 3));
         exmem_regwrite = 1'($urandom_range(0, 1)); exmem_memread = 1'($urandom_range(0, 1));
         exmem_dst = AW'($urandom_range(0, 3));
         memwb_regwrite = 1'($urandom_range(0, 1)); memwb_dst = AW'($urandom_range(0, 3));
         stat_clear = ($urandom_range(0, 19) == 0);
         #2;
         n0 = ref_need1(src0, id_src_used[0]);
         n1 = ref_need1(src1, id_src_used[1]);
         need_m = (n0 > n1) ? n0 : n1;
         exp_stall = (hold_left > 0) || (need_m > 0);
         chk("rnd_fwd", {28'd0, fwd_sel},
             {28'd0, ref_fwd1(src1, id_src_used[1]), ref_fwd1(src0, id_src_used[0])});
         chk("rnd_stall", {31'd0, stall}, {31'd0, exp_stall});
         chk("rnd_bubble", {31'd0, bubble_idex}, {31'd0, exp_stall});
         chk("rnd_flush", {31'd0, flush_ifid}, {31'd0, id_branch & branch_taken & ~exp_stall});
         chk("rnd_cycles16", {16'd0, stall_cycles}, cnt16);
         chk("rnd_cycles2", {30'd0, stall_cycles2}, cnt2);
         @(posedge clk);
         if (stat_clear) begin
            cnt16 = 0; cnt2 = 0;
         end else if (exp_stall) begin
            cnt16 = (cnt16 < 65535) ? cnt16 + 1 : 65535;
            cnt2  = (cnt2 < 3) ? cnt2 + 1 : 3;
         end
         if (hold_left > 0) hold_left = hold_left - 1;
         else if (need_m > 0) hold_left = need_m - 1;
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
